// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit entry block.
// Holds the legal digit-count range, the default reset value and the
// single-digit BCD step helper used by the ripple logic.
package bcd_pkg;

  localparam int DIGITS_MIN          = 1;
  localparam int DIGITS_MAX          = 8;
  localparam int RESET_VALUE_DEFAULT = 1;

  // Steps one BCD digit up or down; returns {carry_or_borrow, new_digit}.
  // Input is assumed to be valid BCD, so the result always stays in 0..9.
  function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic dec);
    logic [4:0] r;
    if (!dec) begin
      r = (d >= 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    end else begin
      r = (d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_entry_key_debounce.sv
// Key conditioner: 2-flop synchroniser, stability filter, rising-edge pulse.
// The filtered level follows the input after DEBOUNCE equal synchronised samples.
// A key already high when reset is released must go low before it can pulse.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic          started;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          settle;

  // The last of DEBOUNCE consecutive samples that disagree with the filtered level.
  assign settle = (sync2 != filt) && (cnt == CW'(DEBOUNCE - 1));
  assign rise   = settle && sync2 && armed;

  // Synchronise, count stable samples, and arm only once the key was seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      filt    <= 1'b0;
      started <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      started <= 1'b1;
      if (started && !sync1) begin
        armed <= 1'b1;
      end
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (settle) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_digit_entry.sv
// Multi-digit BCD entry register stepped by debounced per-digit keys or loaded.
// Key edge to num: 2 + DEBOUNCE + 1 clocks; one action per clock.
// Unserviced presses wait in pending while hold=1 or a higher-priority action runs.
module bcd_digit_entry
  import bcd_pkg::*;
#(
  parameter int                    DIGITS      = 4,
  parameter int                    DEBOUNCE    = 4,
  parameter logic [4*DIGITS-1:0]   RESET_VALUE = (4*DIGITS)'(RESET_VALUE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     key_inc,
  input  logic                  dec_mode,
  input  logic                  carry_en,
  input  logic                  hold,
  input  logic                  load_req,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   num,
  output logic                  ovf,
  output logic                  load_err,
  output logic [DIGITS-1:0]     pending
);

  localparam int W = 4 * DIGITS;

  logic [DIGITS:0]   raw_all;
  logic [DIGITS:0]   rise_all;
  logic [DIGITS-1:0] key_rise;
  logic              load_rise;
  logic              load_go;

  logic [W-1:0]      step_num;
  logic              step_ovf;
  logic [DIGITS-1:0] svc_mask;
  logic              found;
  logic              chain;
  logic              fire;
  logic [4:0]        res;
  logic              load_ok;

  assign raw_all   = {load_req, key_inc};
  assign key_rise  = rise_all[DIGITS-1:0];
  assign load_rise = rise_all[DIGITS];

  // Top entry is the load request; the rest are the digit keys.
  for (genvar g = 0; g <= DIGITS; g++) begin : g_deb
    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_all[g]),
      .rise (rise_all[g])
    );
  end

  // Pick the lowest pending digit and ripple its carry/borrow upward.
  always_comb begin
    svc_mask = '0;
    step_num = num;
    step_ovf = 1'b0;
    found    = 1'b0;
    chain    = 1'b0;
    fire     = 1'b0;
    res      = '0;
    for (int j = 0; j < DIGITS; j++) begin
      fire = 1'b0;
      if (!found && pending[j]) begin
        fire        = 1'b1;
        found       = 1'b1;
        svc_mask[j] = 1'b1;
      end else if (found && carry_en && chain) begin
        fire = 1'b1;
      end
      if (fire) begin
        res               = bcd_step(num[4*j +: 4], dec_mode);
        step_num[4*j +: 4] = res[3:0];
        chain             = res[4];
      end else begin
        chain = 1'b0;
      end
    end
    step_ovf = carry_en && chain;
  end

  // A load is only taken if every nibble is a decimal digit.
  always_comb begin
    load_ok = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (load_data[4*j +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Priority: clr, then the delayed load, then the lowest pending step.
  always_ff @(posedge clk) begin
    if (rst) begin
      num      <= RESET_VALUE;
      pending  <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
      load_go  <= 1'b0;
    end else begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
      load_go  <= load_rise;
      if (clr) begin
        num     <= '0;
        pending <= '0;
      end else if (load_go) begin
        if (load_ok) begin
          num <= load_data;
        end else begin
          load_err <= 1'b1;
        end
        pending <= pending | key_rise;
      end else if (!hold && (|pending)) begin
        num     <= step_num;
        ovf     <= step_ovf;
        pending <= (pending & ~svc_mask) | (key_rise & ~pending);
      end else begin
        pending <= pending | key_rise;
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed scenarios plus randomized presses,
// checked against a decimal-arithmetic model of the entered number.
module tb_bcd_digit_entry;

  localparam int DIGITS   = 4;
  localparam int DEBOUNCE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_inc;
  logic        dec_mode;
  logic        carry_en;
  logic        hold;
  logic        load_req;
  logic [15:0] load_data;
  logic        clr;
  logic [15:0] num;
  logic        ovf;
  logic        load_err;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_pass   = 0;
  int model;

  bcd_digit_entry #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_inc   (key_inc),
    .dec_mode  (dec_mode),
    .carry_en  (carry_en),
    .hold      (hold),
    .load_req  (load_req),
    .load_data (load_data),
    .clr       (clr),
    .num       (num),
    .ovf       (ovf),
    .load_err  (load_err),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v;
    v = 0;
    for (int k = 3; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
    return v;
  endfunction

  // Decimal model: with carry the step is +/- 10^i on the whole number
  // modulo 10^DIGITS; without carry only digit i changes, modulo 10.
  function automatic int stepped(input int v, input int i, input bit dec,
                                 input bit carry, output bit o);
    int p, t, d;
    p = 10 ** i;
    o = 1'b0;
    if (carry) begin
      t = dec ? v - p : v + p;
      o = (t < 0) || (t >= 10000);
      return (t + 10000) % 10000;
    end
    d = (v / p) % 10;
    t = dec ? (d + 9) % 10 : (d + 1) % 10;
    return v - d * p + t * p;
  endfunction

  task automatic load_val(input logic [15:0] d, input string tag);
    bit valid;
    valid = 1'b1;
    for (int k = 0; k < 4; k++) if (d[4*k +: 4] > 4'd9) valid = 1'b0;
    load_data = d;
    load_req  = 1'b1;
    tick(6);
    chk({tag, "_pre"}, num, to_bcd(model));
    tick(1);
    if (valid) model = from_bcd(d);
    chk(tag, num, to_bcd(model));
    chk({tag, "_err"}, load_err, !valid);
    tick(1);
    chk({tag, "_err_pulse"}, load_err, 0);
    load_req = 1'b0;
    tick(8);
  endtask

  task automatic press_and_check(input logic [3:0] mask, input bit dec,
                                 input bit carry, input string tag);
    int ocnt, exp_ocnt;
    bit o;
    dec_mode = dec;
    carry_en = carry;
    key_inc  = mask;
    ocnt     = 0;
    exp_ocnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (ovf) ocnt++;
    end
    key_inc = '0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (ovf) ocnt++;
    end
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        model = stepped(model, i, dec, carry, o);
        if (o) exp_ocnt++;
      end
    end
    chk({tag, "_num"}, num, to_bcd(model));
    chk({tag, "_ovf_count"}, ocnt, exp_ocnt);
    chk({tag, "_pending"}, pending, 0);
  endtask

  initial begin
    bit o;
    rst = 1'b1; key_inc = '0; dec_mode = 1'b0; carry_en = 1'b1; hold = 1'b0;
    load_req = 1'b0; load_data = '0; clr = 1'b0;
    tick(2);
    model = 1;
    chk("reset_num", num, 16'h0001);
    chk("reset_pending", pending, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_load_err", load_err, 0);
    rst = 1'b0;
    tick(3);

    // Ripple carry into higher digits.
    load_val(16'h0999, "ld_0999");
    key_inc = 4'b0001;
    tick(6);
    chk("ripple_pre", num, 16'h0999);
    chk("ripple_pend", pending, 4'b0001);
    tick(1);
    model = stepped(model, 0, 1'b0, 1'b1, o);
    chk("ripple_num", num, to_bcd(model));
    chk("ripple_ovf", ovf, o);
    key_inc = '0;
    tick(8);

    // Overflow out of the top digit.
    load_val(16'h9999, "ld_9999");
    key_inc = 4'b0001;
    tick(7);
    model = stepped(model, 0, 1'b0, 1'b1, o);
    chk("wrap_num", num, to_bcd(model));
    chk("wrap_ovf", ovf, o);
    tick(1);
    chk("wrap_ovf_pulse", ovf, 0);
    key_inc = '0;
    tick(8);

    // Decrement with no carry wraps only the pressed digit.
    load_val(16'h0000, "ld_0000");
    press_and_check(4'b0100, 1'b1, 1'b0, "nocarry_dec");

    // Simultaneous presses serviced one per cycle, lowest first.
    load_val(16'h0000, "ld_0000b");
    carry_en = 1'b1; dec_mode = 1'b0;
    key_inc  = 4'b1010;
    tick(6);
    chk("simul_pend0", pending, 4'b1010);
    tick(1);
    model = stepped(model, 1, 1'b0, 1'b1, o);
    chk("simul_num1", num, to_bcd(model));
    chk("simul_pend1", pending, 4'b1000);
    tick(1);
    model = stepped(model, 3, 1'b0, 1'b1, o);
    chk("simul_num2", num, to_bcd(model));
    chk("simul_pend2", pending, 4'b0000);
    key_inc = '0;
    tick(8);

    // Valid and invalid loads.
    load_val(16'h1234, "ld_1234");
    load_val(16'h12A4, "ld_bad");

    // Bouncing key never settles.
    for (int c = 0; c < 10; c++) begin
      key_inc = 4'b0001; tick(1);
      key_inc = 4'b0000; tick(1);
    end
    tick(8);
    chk("bounce_num", num, to_bcd(model));
    chk("bounce_pend", pending, 0);

    // Hold latches the press but defers the step.
    hold = 1'b1;
    key_inc = 4'b0001;
    tick(7);
    chk("hold_pend", pending, 4'b0001);
    chk("hold_num", num, to_bcd(model));
    key_inc = '0;
    tick(8);
    chk("hold_num_late", num, to_bcd(model));
    hold = 1'b0;
    tick(1);
    model = stepped(model, 0, 1'b0, 1'b1, o);
    chk("hold_release_num", num, to_bcd(model));
    chk("hold_release_pend", pending, 0);

    // clr zeroes num and drops pending presses.
    hold = 1'b1;
    key_inc = 4'b1000;
    tick(7);
    chk("clr_pend_pre", pending, 4'b1000);
    clr = 1'b1;
    tick(1);
    model = 0;
    chk("clr_num", num, 0);
    chk("clr_pend", pending, 0);
    clr = 1'b0; hold = 1'b0; key_inc = '0;
    tick(8);
    chk("clr_num_after", num, 0);

    // A load coinciding with clr is discarded silently.
    load_data = 16'h12A4;
    load_req  = 1'b1;
    tick(6);
    clr = 1'b1;
    tick(1);
    chk("clr_load_num", num, 0);
    chk("clr_load_err", load_err, 0);
    clr = 1'b0;
    tick(1);
    chk("clr_load_err_after", load_err, 0);
    chk("clr_load_num_after", num, 0);
    load_req = 1'b0;
    tick(8);

    // Randomized presses from random starting values.
    for (int it = 0; it < 8; it++) begin
      load_val(to_bcd(int'($urandom_range(0, 9999))), $sformatf("rnd_ld%0d", it));
      press_and_check(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
    end

    // Key held through reset is ignored until released and pressed again.
    carry_en = 1'b1; dec_mode = 1'b0;
    key_inc  = 4'b0001;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model = 1;
    tick(15);
    chk("held_rst_num", num, 16'h0001);
    chk("held_rst_pend", pending, 0);
    key_inc = '0;
    tick(8);
    key_inc = 4'b0001;
    tick(7);
    model = stepped(model, 0, 1'b0, 1'b1, o);
    chk("repress_num", num, to_bcd(model));
    key_inc = '0;
    tick(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_digit_entry.md
BCD_DIGIT_ENTRY -- requirements
Module: bcd_digit_entry

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 Parameter DEBOUNCE, default 4: clock cycles a key must stay stable before it is accepted, minimum 1.
REQ-003 Parameter RESET_VALUE, default 1: value of num after reset, BCD-encoded, width 4*DIGITS.
REQ-004 Port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port key_inc, input, DIGITS bits: raw switch per digit; an accepted rising edge steps that digit.
REQ-007 Port dec_mode, input, 1 bit: 0 = a step increments, 1 = a step decrements.
REQ-008 Port carry_en, input, 1 bit: 1 = carry/borrow ripples into higher digits; 0 = each digit wraps on its own.
REQ-009 Port hold, input, 1 bit: 1 = steps are suppressed but still latched as pending.
REQ-010 Port load_req, input, 1 bit: raw load request; an accepted rising edge loads load_data.
REQ-011 Port load_data, input, 4*DIGITS bits: BCD value to load (from the RAM read path).
REQ-012 Port clr, input, 1 bit: level; zeroes num.
REQ-013 Port num, output, 4*DIGITS bits: current BCD value; digit i occupies bits [4i+3:4i].
REQ-014 Port ovf, output, 1 bit: one-cycle pulse on carry out of, or borrow from, the top digit.
REQ-015 Port load_err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-016 Port pending, output, DIGITS bits: accepted key presses not yet applied.

Function
REQ-017 Each key_inc bit and load_req SHALL pass through a 2-flop synchroniser, then a stability counter: the filtered level changes only after DEBOUNCE consecutive equal samples.
REQ-018 A filtered 0->1 transition of key_inc[i] SHALL set pending[i]; any further edges on that bit while pending[i]=1 are absorbed.
REQ-019 Each cycle, priority SHALL be: clr, then accepted load, then the lowest-index set pending bit (only when hold=0); exactly one action per cycle.
REQ-020 Servicing pending[i] SHALL clear that bit and update num on the same clock edge; other pending bits remain set.
REQ-021 Increment SHALL map 9->0 with a carry; decrement SHALL map 0->9 with a borrow; the result is always valid BCD.
REQ-022 When carry_en=1, carry/borrow SHALL ripple combinationally from digit i through digit DIGITS-1 within the same cycle; digits below i are unchanged.
REQ-023 ovf SHALL pulse when the ripple leaves the top digit (e.g. all-9 +1 -> all-0, all-0 -1 -> all-9), only when carry_en=1.
REQ-024 When carry_en=0, a step SHALL wrap only digit i, and ovf SHALL stay 0.
REQ-025 A load SHALL be accepted one cycle after the filtered load_req rises; if any nibble of load_data is >9, num is unchanged and load_err pulses.
REQ-026 A load occurring in a cycle where clr=1 SHALL be discarded silently (no load_err).
REQ-027 clr=1 SHALL set num to 0 and clear pending; it does not affect the debounce state.
REQ-028 num SHALL be registered: latency from a pending bit being serviced to num changing is 1 clock.
REQ-029 Latency from a raw key rising edge to num changing SHALL be 2 (sync) + DEBOUNCE + 1 cycles when no higher-priority action occurs.

Reset
REQ-030 rst=1 at a rising edge SHALL set num=RESET_VALUE, pending=0, ovf=0, load_err=0, clear all synchroniser and debounce state to 0, and zero all filtered levels.
REQ-031 Reset SHALL override clr, load and steps; a press in progress is lost, and a key held through reset release is not accepted until it has been low and then high again.

Structure
REQ-032 The BCD step helper, the DIGITS range limits and the default RESET_VALUE SHALL live in a shared package bcd_pkg.
REQ-033 A sub-module key_debounce (synchroniser + stability counter + rising-edge pulse, parameter DEBOUNCE) SHALL be instantiated DIGITS+1 times.

Verification
REQ-034 Reset: rst high for 2 cycles -> num=0x0001, pending=0, ovf=0.
REQ-035 Ripple: DIGITS=4, num=0x0999, carry_en=1, press key 0 -> num=0x1000; from 0x9999 -> 0x0000 with a single ovf pulse.
REQ-036 No carry: carry_en=0, dec_mode=1, num=0x0000, press key 2 -> num=0x0900, ovf=0.
REQ-037 Simultaneous: keys 1 and 3 pressed together from 0x0000 -> 0x0010, then 0x1010 one cycle later; pending goes 1010 -> 1000 -> 0000.
REQ-038 Load: load_data=0x1234 -> num=0x1234; load_data=0x12A4 -> num unchanged, load_err pulses once.
REQ-039 Bounce/hold: key toggling with a period shorter than DEBOUNCE -> no change; hold=1 during a press -> pending set and num unchanged until hold=0.
